// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : cordic_pkg
//  Purpose  : Shared widths, fixed-point constants and state encoding for the
//             cordic angle pre-reduction stage.
//  Revision : 1.0  initial release
// ============================================================================
package cordic_pkg;

    // Port angle format: signed Q8.8
    localparam int W     = 16;
    localparam int FRAC  = 8;
    // Extra fraction bits carried internally so reduction error stays below
    // one output LSB before the final round.
    localparam int GUARD = 8;
    // Internal word: Q10.(FRAC+GUARD) -- two extra integer bits of headroom
    localparam int IW    = (W - FRAC) + 2 + FRAC + GUARD;

    // Fixed-point constants, 16 fraction bits
    localparam logic signed [IW-1:0] TWO_PI_Q16     = IW'(32'sh0006487F);
    localparam logic signed [IW-1:0] PI_Q16         = IW'(32'sh0003243F);
    localparam logic signed [IW-1:0] HALF_PI_Q16    = IW'(32'sh00019220);
    localparam logic signed [IW-1:0] SIXTEEN_PI_Q16 = IW'(32'sh003243F0);
    localparam logic signed [IW-1:0] DEG180_Q16     = IW'(32'sh00B40000);
    localparam logic signed [IW-1:0] DEG90_Q16      = IW'(32'sh005A0000);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        FOLD   = 2'd2,
        DONE   = 2'd3
    } red_state_t;

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/cordic_fold.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_fold
//  Purpose  : Combinational quadrant fold of an angle already inside
//             [-P, +P] into [-B, +B], plus round-half-up to Q8.8.
//             B/P = pi/2 / pi in radian mode, 90 / 180 in degree mode.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_fold
    import cordic_pkg::*;
(
    input  logic signed [IW-1:0] i_angle,
    input  logic                 i_radian,
    output logic        [W-1:0]  o_angle,
    output logic                 o_quad_neg
);

    localparam logic signed [IW-1:0] c_round = IW'(1 << (GUARD - 1));

    logic signed [IW-1:0] w_bound;
    logic signed [IW-1:0] w_half_turn;
    logic signed [IW-1:0] w_folded;
    logic signed [IW-1:0] w_rounded;
    logic                 w_neg;
    logic                 w_unused_bits;

    // Mirror across +/-P when outside +/-B; the boundary itself stays put
    always_comb begin
        w_bound     = i_radian ? HALF_PI_Q16 : DEG90_Q16;
        w_half_turn = i_radian ? PI_Q16      : DEG180_Q16;
        w_folded    = i_angle;
        w_neg       = 1'b0;
        if (i_angle > w_bound) begin
            w_folded = w_half_turn - i_angle;
            w_neg    = 1'b1;
        end else if (i_angle < -w_bound) begin
            w_folded = -w_half_turn - i_angle;
            w_neg    = 1'b1;
        end
    end

    // Folded magnitude never exceeds 90, so the Q8.8 slice cannot overflow
    assign w_rounded     = w_folded + c_round;
    assign o_angle       = w_rounded[W+GUARD-1:GUARD];
    assign o_quad_neg    = w_neg;
    assign w_unused_bits = &{1'b0, w_rounded[IW-1:W+GUARD], w_rounded[GUARD-1:0]};

endmodule : cordic_fold
`default_nettype wire

// File: rtl/cordic_angle_reduce.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_angle_reduce
//  Purpose  : Pre-stage for the cordic core. Reduces any signed Q8.8 angle
//             (radians or degrees) into [-pi/2, +pi/2] / [-90, +90] and
//             flags when cos/tan/cot must be negated downstream.
//             Valid/ready handshake on both sides; one request at a time.
//  Options  : CORDIC_RED_COARSE_EN - radian reduction first takes +/-16pi
//             steps while |a| > 16pi, then 2pi steps (worst case 6 steps
//             instead of 20).
//  Revision : 1.0  initial release
// ============================================================================
module cordic_angle_reduce
    import cordic_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         radian_en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] angle,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] angle_red,
    output logic         quad_neg,
    output logic         radian_out,
    output logic         busy
);

    localparam logic signed [IW-1:0] c_neg_pi         = -PI_Q16;
`ifdef CORDIC_RED_COARSE_EN
    localparam logic signed [IW-1:0] c_neg_sixteen_pi = -SIXTEEN_PI_Q16;
`endif

    red_state_t           r_state;
    logic signed [IW-1:0] r_acc;
    logic                 r_radian;
    logic                 r_out_valid;
    logic        [W-1:0]  r_angle_red;
    logic                 r_quad_neg;
    logic                 r_radian_out;

    logic signed [IW-1:0] w_ext;
    logic        [W-1:0]  w_fold_angle;
    logic                 w_fold_neg;

    // Q8.8 -> Q10.16: sign-extend two integer bits, append guard zeros
    assign w_ext = {{(IW - W - GUARD){angle[W-1]}}, angle, {GUARD{1'b0}}};

    cordic_fold u_fold (
        .i_angle    (r_acc),
        .i_radian   (r_radian),
        .o_angle    (w_fold_angle),
        .o_quad_neg (w_fold_neg)
    );

    // Sequencer: accept, iterative 2pi reduction, single-cycle fold, hold result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_radian     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_angle_red  <= '0;
            r_quad_neg   <= 1'b0;
            r_radian_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc    <= w_ext;
                        r_radian <= radian_en;
                        // Degree inputs are already within +/-128, no wrap needed
                        r_state  <= radian_en ? REDUCE : FOLD;
                    end
                end
                REDUCE: begin
`ifdef CORDIC_RED_COARSE_EN
                    if (r_acc > SIXTEEN_PI_Q16) begin
                        r_acc <= r_acc - SIXTEEN_PI_Q16;
                    end else if (r_acc < c_neg_sixteen_pi) begin
                        r_acc <= r_acc + SIXTEEN_PI_Q16;
                    end else
`endif
                    if (r_acc > PI_Q16) begin
                        r_acc <= r_acc - TWO_PI_Q16;
                    end else if (r_acc < c_neg_pi) begin
                        r_acc <= r_acc + TWO_PI_Q16;
                    end else begin
                        r_state <= FOLD;
                    end
                end
                FOLD: begin
                    r_angle_red  <= w_fold_angle;
                    r_quad_neg   <= w_fold_neg;
                    r_radian_out <= r_radian;
                    r_out_valid  <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign out_valid  = r_out_valid;
    assign angle_red  = r_angle_red;
    assign quad_neg   = r_quad_neg;
    assign radian_out = r_radian_out;

endmodule : cordic_angle_reduce
`default_nettype wire

// File: tb/tb_cordic_angle_reduce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_angle_reduce
//  Purpose  : Directed self-checking bench for cordic_angle_reduce.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_angle_reduce;

    logic        clk;
    logic        rst;
    logic        radian_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] angle;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] angle_red;
    logic        quad_neg;
    logic        radian_out;
    logic        busy;

    int n_tests;
    int n_fail;

    cordic_angle_reduce dut (
        .clk        (clk),
        .rst        (rst),
        .radian_en  (radian_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .angle      (angle),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .angle_red  (angle_red),
        .quad_neg   (quad_neg),
        .radian_out (radian_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request, then count edges from the accept edge to out_valid
    task automatic run_job(input string tag, input logic rad, input logic [15:0] ang,
                           input int exp_lat, input logic [15:0] exp_red, input logic exp_qn);
        int lat;
        @(negedge clk);
        radian_en = rad;
        angle     = ang;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, ".busy"}, busy, 1'b1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".angle_red"}, angle_red, exp_red);
        chk({tag, ".quad_neg"}, quad_neg, exp_qn);
        chk({tag, ".radian_out"}, radian_out, rad);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_clr"}, out_valid, 1'b0);
        chk({tag, ".in_ready_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] held;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        radian_en = 1'b0;
        in_valid  = 1'b0;
        angle     = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.angle_red", angle_red, 16'h0000);
        chk("rst.quad_neg", quad_neg, 1'b0);
        chk("rst.radian_out", radian_out, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        // 1.0 rad: no reduction, no fold
        run_job("rad1", 1'b1, 16'h0100, 2, 16'h0100, 1'b0);
        consume("rad1");
        // 4.0 rad: one 2pi step, then folded
        run_job("rad4", 1'b1, 16'h0400, 3, 16'hFF24, 1'b1);
        consume("rad4");
        // 2.0 rad: no reduction, fold to pi-2
        run_job("rad2", 1'b1, 16'h0200, 2, 16'h0124, 1'b1);
        consume("rad2");
        // -1.0 rad: untouched
        run_job("radm1", 1'b1, 16'hFF00, 2, 16'hFF00, 1'b0);
        consume("radm1");
        // -128.0 rad: worst-case reduction
`ifdef CORDIC_RED_COARSE_EN
        run_job("radm128", 1'b1, 16'h8000, 8, 16'hFF32, 1'b1);
`else
        run_job("radm128", 1'b1, 16'h8000, 22, 16'hFF32, 1'b1);
`endif
        consume("radm128");
        // Degree mode
        run_job("deg120", 1'b0, 16'h7800, 1, 16'h3C00, 1'b1);
        consume("deg120");
        run_job("degm90", 1'b0, 16'hA600, 1, 16'hA600, 1'b0);
        consume("degm90");
        run_job("deg90", 1'b0, 16'h5A00, 1, 16'h5A00, 1'b0);
        consume("deg90");
        run_job("degm128", 1'b0, 16'h8000, 1, 16'hCC00, 1'b1);

        // Back-pressure: hold DONE for 5 cycles with stray in_valid pulses
        held = angle_red;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = i[0];
            radian_en = 1'b1;
            angle     = 16'h0100;
            @(posedge clk);
            #1;
            chk("hold.out_valid", out_valid, 1'b1);
            chk("hold.angle_red", angle_red, held);
            chk("hold.quad_neg", quad_neg, 1'b1);
            chk("hold.in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume("hold");
        @(posedge clk);
        #1;
        chk("hold.no_stray_job", busy, 1'b0);

        // Async reset in the middle of a long reduction
        @(negedge clk);
        radian_en = 1'b1;
        angle     = 16'h8000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort.busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("abort.out_valid", out_valid, 1'b0);
        chk("abort.busy", busy, 1'b0);
        chk("abort.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        run_job("after_rst", 1'b1, 16'h0100, 2, 16'h0100, 1'b0);
        consume("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard against a stuck handshake
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_cordic_angle_reduce
`default_nettype wire
